// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump engine: walks addresses 0..NUM_REGS-1 on the read port and
// streams each word with its address over valid/ready, buffering in a 2-entry FIFO.
module regfile_dump_reader #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] infl_addr_q;
    logic [1:0]        used_q;
    logic [DATA_W-1:0] tail_data_q;
    logic [ADDR_W-1:0] tail_addr_q;
    logic              tail_last_q;

    logic       pop;
    logic       push;
    logic       push_last;
    logic       issue;
    logic [2:0] occ;

    // FIFO head lives directly in the out_* registers; the tail slot sits behind it.
    assign out_valid = (used_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;
    assign push_last = (infl_addr_q == LastAddr);

    // Occupancy after this edge, counting the read whose data arrives next cycle.
    always_comb begin
        occ   = {1'b0, used_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == StRun) && (occ < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            used_q      <= 2'd0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            tail_data_q <= '0;
            tail_addr_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                infl_addr_q <= rd_addr;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (rd_addr == LastAddr) begin
                            state_q <= StDrain;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                StDrain: begin
                    // Beats leave in order, so popping the last one empties the pipeline.
                    if (pop && out_last) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            case ({push, pop})
                2'b10: begin
                    if (used_q == 2'd0) begin
                        out_data <= rd_data;
                        out_addr <= infl_addr_q;
                        out_last <= push_last;
                    end else begin
                        tail_data_q <= rd_data;
                        tail_addr_q <= infl_addr_q;
                        tail_last_q <= push_last;
                    end
                    used_q <= used_q + 2'd1;
                end
                2'b01: begin
                    out_data <= tail_data_q;
                    out_addr <= tail_addr_q;
                    out_last <= tail_last_q;
                    used_q   <= used_q - 2'd1;
                end
                2'b11: begin
                    if (used_q == 2'd1) begin
                        out_data <= rd_data;
                        out_addr <= infl_addr_q;
                        out_last <= push_last;
                    end else begin
                        out_data    <= tail_data_q;
                        out_addr    <= tail_addr_q;
                        out_last    <= tail_last_q;
                        tail_data_q <= rd_data;
                        tail_addr_q <= infl_addr_q;
                        tail_last_q <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural 64x32 register file with a write port,
// scoreboard of expected beats pushed at each start and popped on every handshake.
module tb_regfile_dump_reader;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_addr;
    logic        out_last;

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] mem [64];

    beat_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    regfile_dump_reader #(
        .ADDR_W  (6),
        .DATA_W  (32),
        .NUM_REGS(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Register file: registered read, write visible from the following capture.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            wr_en   = 1'b1;
            wr_addr = 6'(i);
            wr_data = 32'(i) * 32'h0101_0101;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic fill_expected(input int ovr_addr, input logic [31:0] ovr_data);
        beat_t b;
        for (int i = 0; i < 64; i++) begin
            b.a = 6'(i);
            b.d = (i == ovr_addr) ? ovr_data : 32'(i) * 32'h0101_0101;
            b.l = (i == 63);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: alternating, 2: random. Optional start pulse / write at a beat.
    task automatic collect(input int mode, input int target, input int start_beat,
                           input int wr_beat, input bit expect_done, output int cycles);
        int          got       = 0;
        int          cyc       = 0;
        int          done_seen = 0;
        bit          stalled   = 0;
        bit          st_done   = 0;
        bit          wr_done   = 0;
        bit          r;
        logic [31:0] hd;
        logic [5:0]  ha;
        beat_t       e;
        while (got < target && cyc < 2000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            start = (got == start_beat) && !st_done;
            if (start) st_done = 1;
            wr_en = (got == wr_beat) && !wr_done;
            if (wr_en) begin
                wr_done = 1;
                wr_addr = 6'd50;
                wr_data = 32'hDEAD_BEEF;
            end
            if (done) done_seen++;
            if (out_valid) begin
                if (stalled) begin
                    n_cmp++;
                    if (out_data !== hd || out_addr !== ha) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h@%0d want %h@%0d", out_data, out_addr,
                                 hd, ha);
                    end
                end
                if (r) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat: got addr %0d want no beat", out_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_addr !== e.a || out_data !== e.d || out_last !== e.l) begin
                            n_fail++;
                            $display("FAIL beat: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                                     out_addr, out_data, out_last, e.a, e.d, e.l);
                        end
                    end
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = out_data;
                    ha = out_addr;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        n_cmp++;
        if (got < target) begin
            n_fail++;
            $display("FAIL beat_timeout: got %0d beats want %0d", got, target);
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL early_done: got %0d pulses want 0", done_seen);
        end
        if (expect_done) begin
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 0 0",
                         done, busy, out_valid);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_width: got %b want 0", done);
            end
        end
        cycles = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid, out_last, out_addr, out_data, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got b=%b d=%b v=%b l=%b a=%0d data=%h ra=%0d want 0",
                     busy, done, out_valid, out_last, out_addr, out_data, rd_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_speed();
        int cyc;
        fill_expected(-1, 32'h0);
        do_start();
        n_cmp++;
        if (busy !== 1'b1 || rd_addr !== 6'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_edge: got busy=%b ra=%0d v=%b want 1 0 0", busy, rd_addr,
                     out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_e1: got valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL latency_e2: got valid=%b a=%0d want 1 0", out_valid, out_addr);
        end
        collect(0, 64, -1, -1, 1'b1, cyc);
        n_cmp++;
        if (cyc != 64) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles want 64", cyc);
        end
    endtask

    task automatic test_backpressure(input int mode);
        int cyc;
        fill_expected(-1, 32'h0);
        do_start();
        collect(mode, 64, -1, -1, 1'b1, cyc);
    endtask

    task automatic test_long_stall();
        int cyc;
        fill_expected(-1, 32'h0);
        out_ready = 1'b0;
        do_start();
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_addr !== 6'd0 || rd_addr !== 6'd2) begin
            n_fail++;
            $display("FAIL stall_issue: got v=%b a=%0d ra=%0d want 1 0 2", out_valid, out_addr,
                     rd_addr);
        end
        collect(0, 64, -1, -1, 1'b1, cyc);
    endtask

    task automatic test_restart_ignored();
        int cyc;
        fill_expected(-1, 32'h0);
        do_start();
        collect(0, 64, 10, -1, 1'b1, cyc);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart: got v=%b busy=%b left=%0d want 0 0 0", out_valid, busy,
                     exp_q.size());
        end
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        fill_expected(-1, 32'h0);
        do_start();
        collect(0, 30, -1, -1, 1'b0, cyc);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got v=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        fill_expected(-1, 32'h0);
        do_start();
        collect(0, 64, -1, -1, 1'b1, cyc);
    endtask

    task automatic test_coherency();
        int cyc;
        fill_expected(50, 32'hDEAD_BEEF);
        do_start();
        collect(0, 64, -1, 5, 1'b1, cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        test_reset();
        preload();
        test_full_speed();
        test_backpressure(1);
        test_backpressure(2);
        test_long_stall();
        test_restart_ignored();
        test_reset_mid_dump();
        test_coherency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
